q2_sequencer: RTL and testbench
===============================

// Module: q2_sequencer
// PURPOSE
//  Timing/state generator for the Q2 CPU: drives state bits s0..s3 and write
//  strobe ws that the control decoder turns into register/memory strobes.
//  Walks FETCH->LOAD->[DEREF]->EXEC->[ALU serial steps] per instruction,
//  two clocks per state (settle, then strobe). Gates execution with run/step.
// PARAMETERS
//  ALU_STEPS  8  serial ALU/shift steps after EXEC (legal 1..12; state 4..3+ALU_STEPS)
// PORTS
//  clk      in   1  system clock, all logic on rising edge
//  rst_n    in   1  synchronous reset, active low
//  run      in   1  level: keep issuing instructions while high
//  step     in   1  1-clk pulse: execute exactly one instruction
//  op2      in   1  opcode bit 2 (1 = indirect -> DEREF state)
//  op3      in   1  opcode bit 3
//  op4      in   1  opcode bit 4
//  op5      in   1  opcode bit 5
//  s0..s3   out  1  state bits, s0 = LSB of 4-bit state
//  ws       out  1  write strobe, high in phase 1 of each active state
//  running  out  1  high while an instruction is in progress
//  done     out  1  1-clk pulse on the last strobe clock of an instruction
// BEHAVIOUR
//  Clock/reset: one clock clk; reset rst_n is synchronous, active-low.
//  Reset: state=0 (FETCH), phase=0, ws=0, running=0, done=0, step_pend=0.
//   Reset mid-instruction aborts it at the next edge; no strobe is issued.
//  Registers: st[3:0], phase, running, step_pend. ws = running & phase (comb).
//  step pulse sets step_pend (sticky until consumed); pulse while running is
//   held and consumed at the next start.
//  Idle (running=0): st held 0, ws=0. Start when run | step | step_pend:
//   running<=1, phase<=0, step_pend<=0. run and step together: run wins,
//   step_pend still cleared.
//  Active: phase toggles every clk. phase 0: ws=0 (operands settle).
//   phase 1: ws=1; at end of phase 1 st advances per table:
//   0 FETCH  -> 1
//   1 LOAD   -> 2 if op2 else 3
//   2 DEREF  -> 3
//   3 EXEC   -> 4 if alu_op else 0
//   4..3+ALU_STEPS-1 -> st+1
//   3+ALU_STEPS -> 0
//   alu_op = ~op5 | (~op3 & ~op4). op bits sampled on the advancing edge
//   only (valid after FETCH strobe); changes in phase 0 are ignored.
//  End of instruction (advance to 0): done=1 for that phase-1 clock;
//   running stays 1 iff run=1 at that edge, or step_pend set, else ->0.
//   Continuing from done returns directly to FETCH phase 0, no idle clock.
//  Latency (clocks, start to done inclusive): plain 6; indirect 8;
//   ALU 6+2*ALU_STEPS; indirect ALU 8+2*ALU_STEPS.
//  st never exceeds 3+ALU_STEPS; any illegal st (fault) -> 0 next edge.
//  run dropped mid-instruction: current instruction completes, then idle.
// STRUCTURE
//  Shared package/header: state constants Q2_ST_FETCH=0, Q2_ST_LOAD=1,
//   Q2_ST_DEREF=2, Q2_ST_EXEC=3, Q2_ST_ALU0=4; shared with q2_control tb.
//  Single module, no sub-module; next-state table as one combinational
//   block plus registers. Bench instantiates q2_control on s0..s3/ws.
// TESTING
//  1 rst_n=0 2 clks mid-ALU -> st=0, ws=0, running=0 next edge, no done.
//  2 step pulse, op=6'b100000 (op5=1,op2=0,op4/3=0 -> alu) -> wait; choose
//    op5=1,op4=1,op3=1: states 0,1,3 each 2 clks, ws in clks 2/4/6, done at
//    clk 6, then idle.
//  3 step, op2=1 op5=1 op4=1 op3=0 -> states 0,1,2,3, done at clk 8.
//  4 run=1, op5=0 (ALU), ALU_STEPS=8 -> 0,1,3,4..11, done clk 22, FETCH
//    phase 0 next clk with running=1.
//  5 run=1 then run=0 during EXEC -> instruction finishes, running=0 after done.
//  6 step pulsed while running with run=0 -> exactly one extra instruction.

Source files
------------

// File: rtl/q2_pkg.sv
// Shared Q2 sequencer definitions: state encodings and the ALU-class opcode decode.
package q2_pkg;

  localparam logic [3:0] Q2_ST_FETCH = 4'd0;
  localparam logic [3:0] Q2_ST_LOAD  = 4'd1;
  localparam logic [3:0] Q2_ST_DEREF = 4'd2;
  localparam logic [3:0] Q2_ST_EXEC  = 4'd3;
  localparam logic [3:0] Q2_ST_ALU0  = 4'd4;

  // Opcodes that need the serial ALU/shift steps after EXEC.
  function automatic logic q2_alu_op(input logic op3, input logic op4, input logic op5);
    return ~op5 | (~op3 & ~op4);
  endfunction

endpackage

// File: rtl/q2_sequencer.sv
// Q2 CPU timing/state generator: two clocks per state (settle, strobe),
// FETCH -> LOAD -> [DEREF] -> EXEC -> [ALU steps], gated by run/step.
module q2_sequencer
  import q2_pkg::*;
#(
  parameter int ALU_STEPS = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic step,
  input  logic op2,
  input  logic op3,
  input  logic op4,
  input  logic op5,
  output logic s0,
  output logic s1,
  output logic s2,
  output logic s3,
  output logic ws,
  output logic running,
  output logic done
);

  localparam logic [3:0] ST_LAST = 4'(3 + ALU_STEPS);

  logic [3:0] r_st;
  logic       r_phase;
  logic       r_running;
  logic       r_step_pend;

  logic [3:0] w_st_next;
  logic       w_st_legal;
  logic       w_end;
  logic       w_continue;

  assign w_st_legal = (r_st <= ST_LAST);
  assign w_continue = run | step | r_step_pend;

  always_comb begin
    w_st_next = Q2_ST_FETCH;
    if (w_st_legal) begin
      case (r_st)
        Q2_ST_FETCH: w_st_next = Q2_ST_LOAD;
        Q2_ST_LOAD:  w_st_next = op2 ? Q2_ST_DEREF : Q2_ST_EXEC;
        Q2_ST_DEREF: w_st_next = Q2_ST_EXEC;
        Q2_ST_EXEC:  w_st_next = q2_alu_op(op3, op4, op5) ? Q2_ST_ALU0 : Q2_ST_FETCH;
        default:     w_st_next = (r_st == ST_LAST) ? Q2_ST_FETCH : r_st + 4'd1;
      endcase
    end
  end

  // Last strobe clock of an instruction: the advance lands back on FETCH.
  assign w_end = r_running & r_phase & w_st_legal & (w_st_next == Q2_ST_FETCH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_st        <= Q2_ST_FETCH;
      r_phase     <= 1'b0;
      r_running   <= 1'b0;
      r_step_pend <= 1'b0;
    end else begin
      if (step) r_step_pend <= 1'b1;
      if (!r_running) begin
        r_st    <= Q2_ST_FETCH;
        r_phase <= 1'b0;
        if (w_continue) begin
          r_running   <= 1'b1;
          r_step_pend <= 1'b0;
        end
      end else if (!w_st_legal) begin
        r_st    <= Q2_ST_FETCH;
        r_phase <= 1'b0;
      end else begin
        r_phase <= ~r_phase;
        if (r_phase) begin
          r_st <= w_st_next;
          if (w_end) begin
            // A pending step is consumed by the instruction that follows directly.
            if (w_continue) r_step_pend <= 1'b0;
            else            r_running   <= 1'b0;
          end
        end
      end
    end
  end

  assign {s3, s2, s1, s0} = r_st;
  assign ws      = r_running & r_phase;
  assign running = r_running;
  assign done    = w_end;

endmodule

// File: tb/tb_q2_sequencer.sv
// Directed scoreboard bench for q2_sequencer: expected per-clock state/strobe
// tuples are queued as stimulus is driven and popped on each falling edge.
module tb_q2_sequencer;
  import q2_pkg::*;

  logic clk = 1'b0;
  logic rst_n, run, step, op2, op3, op4, op5;
  logic s0, s1, s2, s3, ws, running, done;

  int n_cmp = 0;
  int n_err = 0;

  logic [6:0] exp_q[$];
  string      tag_q[$];

  q2_sequencer #(.ALU_STEPS(8)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step),
    .op2(op2), .op3(op3), .op4(op4), .op5(op5),
    .s0(s0), .s1(s1), .s2(s2), .s3(s3),
    .ws(ws), .running(running), .done(done)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [3:0] st, input logic w, input logic r, input logic d,
                      input string tag);
    exp_q.push_back({st, w, r, d});
    tag_q.push_back(tag);
  endtask

  // One state = settle clock then strobe clock.
  task automatic push_state(input logic [3:0] st, input logic last, input string tag);
    push(st, 1'b0, 1'b1, 1'b0, tag);
    push(st, 1'b1, 1'b1, last, tag);
  endtask

  task automatic push_idle(input string tag);
    push(Q2_ST_FETCH, 1'b0, 1'b0, 1'b0, tag);
  endtask

  task automatic cyc(input int n);
    logic [6:0] obs;
    logic [6:0] e;
    string      t;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      obs = {s3, s2, s1, s0, ws, running, done};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $error("FAIL scoreboard_empty: observed %b, required a queued expectation", obs);
      end else begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        assert (obs === e) else begin
          n_err++;
          $error("FAIL %s: observed st=%0d ws=%b run=%b done=%b, expected st=%0d ws=%b run=%b done=%b",
                 t, obs[6:3], obs[2], obs[1], obs[0], e[6:3], e[2], e[1], e[0]);
        end
        $display("%-14s st=%0d ws=%b running=%b done=%b", t, obs[6:3], obs[2], obs[1], obs[0]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; step = 1'b0;
    op2 = 1'b0; op3 = 1'b0; op4 = 1'b0; op5 = 1'b0;
    @(posedge clk);
    #1;

    // Reset state
    push_idle("reset"); push_idle("reset");
    cyc(2);
    rst_n = 1'b1;
    push_idle("post_reset");
    cyc(1);

    // Single-step, plain instruction: 0,1,3 -> done at clock 6, then idle
    {op5, op4, op3, op2} = 4'b1110;
    step = 1'b1;
    push_idle("plain_pre");
    cyc(1);
    step = 1'b0;
    push_state(Q2_ST_FETCH, 1'b0, "plain");
    push_state(Q2_ST_LOAD,  1'b0, "plain");
    push_state(Q2_ST_EXEC,  1'b1, "plain");
    push_idle("plain_idle"); push_idle("plain_idle");
    cyc(8);

    // Single-step, indirect non-ALU: 0,1,2,3 -> done at clock 8
    {op5, op4, op3, op2} = 4'b1101;
    step = 1'b1;
    push_idle("indir_pre");
    cyc(1);
    step = 1'b0;
    push_state(Q2_ST_FETCH, 1'b0, "indirect");
    push_state(Q2_ST_LOAD,  1'b0, "indirect");
    push_state(Q2_ST_DEREF, 1'b0, "indirect");
    push_state(Q2_ST_EXEC,  1'b1, "indirect");
    push_idle("indir_idle");
    cyc(9);

    // Free run, ALU op (op5=0): 0,1,3,4..11, done at clock 22, straight back to FETCH
    {op5, op4, op3, op2} = 4'b0000;
    run = 1'b1;
    push_idle("alu_pre");
    cyc(1);
    push_state(Q2_ST_FETCH, 1'b0, "alu");
    push_state(Q2_ST_LOAD,  1'b0, "alu");
    push_state(Q2_ST_EXEC,  1'b0, "alu");
    for (int k = 4; k <= 11; k++) push_state(4'(k), (k == 11), "alu");
    cyc(6);
    {op5, op4, op3, op2} = 4'b1110;
    cyc(16);
    // Second instruction continues with no idle clock; run drops during EXEC
    push_state(Q2_ST_FETCH, 1'b0, "run_drop");
    push_state(Q2_ST_LOAD,  1'b0, "run_drop");
    push_state(Q2_ST_EXEC,  1'b1, "run_drop");
    push_idle("run_drop_idle"); push_idle("run_drop_idle");
    cyc(4);
    run = 1'b0;
    cyc(4);

    // Step pulsed while running: exactly one extra instruction
    step = 1'b1;
    push_idle("step2_pre");
    cyc(1);
    step = 1'b0;
    push_state(Q2_ST_FETCH, 1'b0, "step2_a");
    push_state(Q2_ST_LOAD,  1'b0, "step2_a");
    push_state(Q2_ST_EXEC,  1'b1, "step2_a");
    push_state(Q2_ST_FETCH, 1'b0, "step2_b");
    push_state(Q2_ST_LOAD,  1'b0, "step2_b");
    push_state(Q2_ST_EXEC,  1'b1, "step2_b");
    push_idle("step2_idle"); push_idle("step2_idle"); push_idle("step2_idle");
    cyc(2);
    step = 1'b1;
    cyc(1);
    step = 1'b0;
    cyc(12);

    // Reset in the middle of the ALU steps: abort with no strobe and no done
    {op5, op4, op3, op2} = 4'b0000;
    run = 1'b1;
    push_idle("rst_mid_pre");
    cyc(1);
    push_state(Q2_ST_FETCH, 1'b0, "rst_mid");
    push_state(Q2_ST_LOAD,  1'b0, "rst_mid");
    push_state(Q2_ST_EXEC,  1'b0, "rst_mid");
    push_state(4'd4, 1'b0, "rst_mid");
    push_state(4'd5, 1'b0, "rst_mid");
    cyc(10);
    push(4'd6, 1'b0, 1'b1, 1'b0, "rst_mid");
    rst_n = 1'b0;
    run = 1'b0;
    cyc(1);
    push_idle("rst_mid_abort"); push_idle("rst_mid_abort");
    cyc(2);
    rst_n = 1'b1;
    push_idle("rst_mid_after");
    cyc(1);

    n_cmp++;
    assert (exp_q.size() == 0) else begin
      n_err++;
      $error("FAIL scoreboard_leftover: observed %0d entries, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
